// File: rtl/pmem_responder_pkg.sv
// pmem_responder_pkg: shared LC-3b line types and the responder FSM state encoding.
package pmem_responder_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_cache_line;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;
endpackage

// File: rtl/pmem_line_array.sv
// pmem_line_array: single-port synchronous line RAM with registered read, no reset.
module pmem_line_array #(
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [127:0]          wdata,
  output logic [127:0]          rdata
);
  logic [127:0] mem [2**INDEX_BITS];
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: latency-programmable responder for cache line read/write requests.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_addr,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_busy,
  output logic         proto_err
);
  pmem_state_t state, state_n;
  logic [7:0] cnt;
  logic op_wr, rd_ok, req, held, rd_en, we;
  logic [INDEX_BITS-1:0] idx, ram_idx;
  lc3b_cache_line wdata_q, ram_q;
  logic unused_addr;
  assign unused_addr = ^{pmem_addr[15:INDEX_BITS+4], pmem_addr[3:0]};
  assign req = pmem_read | pmem_write;
  assign held = op_wr ? pmem_write : pmem_read;
  always_comb begin
    state_n = state == IDLE ? (req ? (LATENCY == 1 ? RESP : BUSY) : IDLE) :
              state == BUSY ? (!held ? IDLE : cnt == 8'd1 ? RESP : BUSY) : IDLE;
    // The RAM read is issued on the edge entering RESP; from IDLE the op is still on the pins.
    rd_en = state_n == RESP && state != RESP && !(state == IDLE ? pmem_write : op_wr);
    we = state == RESP && op_wr;
    ram_idx = state == IDLE ? pmem_addr[INDEX_BITS+3:4] : idx;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      idx <= '0;
      wdata_q <= '0;
      rd_ok <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        op_wr <= pmem_write;
        idx <= pmem_addr[INDEX_BITS+3:4];
        wdata_q <= pmem_wdata;
        cnt <= 8'(LATENCY - 1);
      end else if (state == BUSY) cnt <= cnt - 8'd1;
      if (rd_en) rd_ok <= 1'b1;
    end
  end
  pmem_line_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk(clk), .we(we), .re(rd_en), .idx(ram_idx), .wdata(wdata_q), .rdata(ram_q)
  );
  // The RAM has no reset, so rdata reads as zero until the first read after reset.
  assign pmem_rdata = rd_ok ? ram_q : '0;
  assign pmem_resp = state == RESP;
  assign pmem_busy = state != IDLE;
  assign proto_err = !reset && state == IDLE && pmem_read && pmem_write;
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: scoreboard bench driving a LATENCY=4 and a LATENCY=1 responder.
module tb_pmem_responder;
  typedef struct {
    int           due;
    bit           rd;
    logic [127:0] data;
  } sb_t;
  logic clk = 0, reset = 1;
  logic         rd [2], wr [2], resp [2], busy [2], perr [2];
  logic [15:0]  addr [2];
  logic [127:0] wdata [2], rdata [2];
  logic [127:0] mem_m [int];
  logic [127:0] last_rd [2];
  sb_t q0[$], q1[$];
  sb_t e0, e1;
  int cyc = 0, checks = 0, failures = 0;
  pmem_responder #(.LATENCY(4), .INDEX_BITS(8)) u0 (
    .clk(clk), .reset(reset), .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_addr(addr[0]),
    .pmem_wdata(wdata[0]), .pmem_rdata(rdata[0]), .pmem_resp(resp[0]), .pmem_busy(busy[0]),
    .proto_err(perr[0])
  );
  pmem_responder #(.LATENCY(1), .INDEX_BITS(8)) u1 (
    .clk(clk), .reset(reset), .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_addr(addr[1]),
    .pmem_wdata(wdata[1]), .pmem_rdata(rdata[1]), .pmem_resp(resp[1]), .pmem_busy(busy[1]),
    .proto_err(perr[1])
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (resp[0]) begin
      if (q0.size() == 0) check("unexp_resp0", 1, 0);
      else begin
        e0 = q0.pop_front();
        check("resp_cycle0", cyc, e0.due);
        if (e0.rd) check("rdata0", rdata[0], e0.data);
      end
    end
    if (resp[1]) begin
      if (q1.size() == 0) check("unexp_resp1", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("resp_cycle1", cyc, e1.due);
        if (e1.rd) check("rdata1", rdata[1], e1.data);
      end
    end
  end
  // Called #1 after a rising edge; that cycle is cycle 0 of the request.
  task automatic req(input int d, input bit r, input bit w, input logic [15:0] a,
                     input logic [127:0] wd, input int lat);
    sb_t e;
    bit got = 0;
    e.due = cyc + lat;
    e.rd = r && !w;
    e.data = '0;
    if (w) mem_m[int'(a[11:4])] = wd;
    else if (r) begin
      e.data = mem_m[int'(a[11:4])];
      last_rd[d] = e.data;
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
    @(negedge clk);
    check("proto_err", {127'b0, perr[d]}, {127'b0, r && w});
    check("busy_idle", {127'b0, busy[d]}, 0);
    check("resp_idle", {127'b0, resp[d]}, 0);
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      addr[d] = 16'($urandom);
      wdata[d] = {4{$urandom}};
      if (resp[d]) begin
        got = 1;
        check("busy_resp", {127'b0, busy[d]}, 1);
      end
    end
    if (!got) check("timeout", 0, 1);
    @(posedge clk); #1;
    rd[d] = 0; wr[d] = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      rd[d] = 0; wr[d] = 0; addr[d] = '0; wdata[d] = '0; last_rd[d] = '0;
    end
    @(posedge clk); #1;
    check("rst_resp", {127'b0, resp[0]}, 0);
    check("rst_busy", {127'b0, busy[0]}, 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_perr", {127'b0, perr[0]}, 0);
    reset = 0;
    idle(1);
    req(0, 0, 1, 16'h0080, {4{32'h1234_5678}}, 4);
    req(0, 0, 1, 16'h0300, {8{16'h5555}}, 4);
    req(0, 0, 1, 16'h0120, {16{8'hAA}}, 4);
    idle(2);
    req(0, 1, 0, 16'h0120, 0, 4);
    req(0, 1, 0, 16'hF12F, 0, 4);
    idle(1);
    req(0, 0, 1, 16'h0040, {16{8'hCC}}, 4);
    req(0, 1, 0, 16'h0080, 0, 4);
    idle(1);
    req(0, 1, 1, 16'h0500, {16{8'h77}}, 4);
    @(negedge clk);
    check("rdata_held", rdata[0], last_rd[0]);
    idle(1);
    req(0, 1, 0, 16'h0500, 0, 4);
    idle(1);
    rd[0] = 0; wr[0] = 1; addr[0] = 16'h0300; wdata[0] = {4{32'hDEAD_BEEF}};
    idle(2);
    wr[0] = 0;
    @(negedge clk);
    check("abort_busy2", {127'b0, busy[0]}, 1);
    idle(1);
    @(negedge clk);
    check("abort_idle3", {127'b0, busy[0]}, 0);
    idle(6);
    req(0, 1, 0, 16'h0300, 0, 4);
    rd[0] = 1; addr[0] = 16'h0040;
    idle(2);
    @(negedge clk);
    check("mid_busy", {127'b0, busy[0]}, 1);
    #2 reset = 1;
    #1;
    check("arst_busy", {127'b0, busy[0]}, 0);
    check("arst_resp", {127'b0, resp[0]}, 0);
    check("arst_rdata", rdata[0], 0);
    idle(1);
    rd[0] = 0; reset = 0;
    idle(6);
    req(0, 1, 0, 16'h0120, 0, 4);
    req(1, 0, 1, 16'h0010, {4{32'h0BAD_F00D}}, 1);
    req(1, 1, 0, 16'h0010, 0, 1);
    @(negedge clk);
    check("lat1_busy_after", {127'b0, busy[1]}, 0);
    idle(4);
    check("sb_drain", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
